ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Read-side initiator for `dual_port_sync_ram`. On a start command it walks a contiguous address range through the RAM read port and presents the words as a valid/ready stream. It accounts for the RAM's one-cycle registered read latency and absorbs downstream back-pressure in a 2-entry output buffer. It sits between the RAM read port and any consumer (UART TX, checksum, DMA sink) that drains a buffered block.

## Interface
- `ram_width`, 8: data word width; must equal the RAM's `ram_width`.
- `ram_address`, 10: address width; must equal the RAM's `ram_address`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; sampled only while idle.
- `start_address`  in  ram_address  first word address; captured with `start`.
- `burst_length`  in  ram_address+1  number of words, 0..2^ram_address; captured with `start`.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse at burst completion.
- `read_enable`  out  1  to RAM `read_enable`.
- `address_read`  out  ram_address  to RAM `address_read`.
- `ram_data`  in  ram_width  from RAM `data_out`.
- `out_data`  out  ram_width  stream word.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word when high with `out_valid`.
- `out_last`  out  1  marks the final word of a burst; qualified by `out_valid`.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - `start`=1 latches `start_address` into the address counter and `burst_length` into the issue and accept counters.
  - Goes to RUN if length>0, else to FINISH.
  - `start` while not IDLE is ignored.
- RUN, issue:
  - `read_enable` = (issue count>0) && (occupancy + inflight − pop < 2), where pop = `out_valid && out_ready`.
  - The term is combinational from registered state and `out_ready`.
  - `address_read` = address counter. Each issue increments it, wrapping modulo 2^ram_address (1023→0 at default), and decrements the issue count.
- Capture:
  - Registered `inflight` = `read_enable` delayed one cycle.
  - When `inflight`=1, `ram_data` is written into the buffer at the next edge.
  - `ram_data` is never sampled in any other cycle.
- Buffer:
  - 2-entry FIFO; `out_data` is its head.
  - Simultaneous push and pop is legal and keeps occupancy unchanged.
  - The issue rule guarantees it never overflows.
- `out_last` = `out_valid` && accept count == 1.
- Each handshake decrements the accept count. When the final handshake occurs, go to FINISH.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `busy` = state != IDLE, so it includes FINISH.
- Reset at any time:
  - Returns to IDLE and flushes buffer, inflight and counters.
  - All outputs go to 0: `busy`, `done`, `read_enable`, `address_read`, `out_valid`, `out_data`, `out_last`.
  - No partial burst resumes.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=1, first `read_enable`=1 with `address_read`=start.
- Cycle 2: `ram_data` valid.
- Cycle 3: first `out_valid`=1.
- With `out_ready` held high, one word per cycle. An N-word burst has `out_valid` in cycles 3..N+2, `out_last` in cycle N+2, and `done` in cycle N+3. `busy` is high in cycles 1..N+3.
- Length 0: no reads issued; `busy` and `done` are both high in cycle 1 only.
- Back-pressure:
  - When `out_ready` drops, at most 2 words are issued beyond the last accepted word.
  - `read_enable` falls in the same cycle that the buffer would otherwise overflow.
  - `out_data`, `out_last` and `out_valid` hold stable while `out_valid && !out_ready`.
- Release: when `out_ready` returns, output resumes in the same cycle from the buffer. Reissue restarts in that cycle.
- Back-to-back bursts: a new `start` is accepted at the earliest in the cycle after `done`.

## Test plan
- **Basic burst:** RAM preloaded mem[i]=i; start addr 5, len 4, `out_ready`=1. Required: `out_data` 5,6,7,8 in cycles 3..6, `out_last` in cycle 6, `done` in cycle 7.
- **Wrap-around:** start addr 1022, len 4. Required: addresses 1022,1023,0,1; data mem[1022],mem[1023],mem[0],mem[1].
- **Back-pressure:** len 8, `out_ready` toggles 1,0,0,1,… (pseudo-random, also held low for 10 cycles). Required:
  - All 8 words delivered in order, none dropped or duplicated.
  - `read_enable` never asserted when occupancy+inflight would exceed 2.
  - Output stable while stalled.
- **Zero length and busy-start:** len 0. Required: no `read_enable`, `done` pulses in cycle 1. During a len-16 burst, pulse `start` with addr 100: ignored, original burst completes unchanged.
- **Full-memory burst:** len 1024 from addr 0. Required: 1024 beats, `out_last` only on the last beat, `done` exactly once.
- **Mid-burst reset:** assert `rst` asynchronously mid-burst. Required: all outputs 0 immediately and buffer empty. A subsequent start addr 10, len 2 yields exactly mem[10],mem[11].

Source files
------------

// File: rtl/ram_burst_reader.sv
// Read-side initiator for dual_port_sync_ram: walks an address range and streams
// the returned words out through a 2-entry valid/ready buffer.
module ram_burst_reader #(
    parameter int ram_width   = 8,
    parameter int ram_address = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ram_address-1:0] start_address,
    input  logic [ram_address:0]   burst_length,
    output logic                   busy,
    output logic                   done,
    output logic                   read_enable,
    output logic [ram_address-1:0] address_read,
    input  logic [ram_width-1:0]   ram_data,
    output logic [ram_width-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    // state  | meaning
    // IDLE   | waiting for start; counters hold their last values
    // RUN    | issuing reads and draining the buffer until the last handshake
    // FINISH | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [ram_address-1:0] ADDR_ONE = 1;
    localparam logic [ram_address:0]   CNT_ONE  = 1;
    localparam logic [ram_address:0]   CNT_ZERO = '0;

    state_t                 state;
    state_t                 state_nxt;
    logic [ram_address-1:0] addr_cnt;
    logic [ram_address:0]   issue_cnt;
    logic [ram_address:0]   accept_cnt;
    logic                   inflight;
    logic [ram_width-1:0]   buf_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             occ;
    logic                   push;
    logic                   pop;
    logic                   room;
    logic                   issue;
    logic                   start_ok;

    assign push      = inflight;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_mem[rd_ptr];
    assign out_last  = out_valid && (accept_cnt == CNT_ONE);

    // Words already owed to the buffer (stored + in flight) minus the one leaving
    // this cycle must stay below 2, otherwise the next capture would overflow.
    assign room  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue = (state == RUN) && (issue_cnt != CNT_ZERO) && room;

    assign read_enable  = issue;
    assign address_read = addr_cnt;
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);
    assign start_ok     = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_length == CNT_ZERO) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && (accept_cnt == CNT_ONE)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt   <= '0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_ok) begin
                addr_cnt   <= start_address;
                issue_cnt  <= burst_length;
                accept_cnt <= burst_length;
            end else begin
                if (issue) begin
                    addr_cnt  <= addr_cnt + ADDR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                end
                if (pop) begin
                    accept_cnt <= accept_cnt - CNT_ONE;
                end
            end
        end
    end

    // ram_data is only meaningful the cycle after a read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= ram_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: behavioural RAM, queue scoreboard fed at start time,
// independent monitor checking addresses, beats, stalls and outstanding reads.
module tb_ram_burst_reader;

    localparam int W     = 8;
    localparam int A     = 10;
    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [A-1:0]   start_address;
    logic [A:0]     burst_length;
    logic           busy;
    logic           done;
    logic           read_enable;
    logic [A-1:0]   address_read;
    logic [W-1:0]   ram_data = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    ram_burst_reader #(.ram_width(W), .ram_address(A)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_address(start_address),
        .burst_length(burst_length),
        .busy(busy),
        .done(done),
        .read_enable(read_enable),
        .address_read(address_read),
        .ram_data(ram_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; output is scrambled on cycles without a read so any
    // capture at the wrong time shows up as a data error.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (read_enable) ram_data <= mem[address_read];
        else             ram_data <= W'($urandom);
    end

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [A-1:0] addr_q[$];
    int total = 0;
    int bad = 0;
    int exp_dones = 0;
    int seen_dones = 0;
    int ready_mode = 0;
    int rcnt = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic queue_burst(input int addr, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = mem[(addr + i) % DEPTH];
            b.last = (i == len - 1);
            exp_q.push_back(b);
            addr_q.push_back(A'((addr + i) % DEPTH));
        end
        exp_dones++;
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle 1.
    task automatic start_burst(input int addr, input int len);
        start_address = A'(addr);
        burst_length  = (A+1)'(len);
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic timing_burst(input int addr, input int len);
        int n;
        queue_burst(addr, len);
        start_burst(addr, len);
        n = (len == 0) ? 2 : len + 4;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (len == 0) begin
                chk($sformatf("z%0d_busy", k), busy, int'(k == 1));
                chk($sformatf("z%0d_done", k), done, int'(k == 1));
                chk($sformatf("z%0d_re", k), read_enable, 0);
            end else begin
                chk($sformatf("t%0d_busy", k), busy, int'(k <= len + 3));
                chk($sformatf("t%0d_done", k), done, int'(k == len + 3));
                chk($sformatf("t%0d_valid", k), out_valid, int'(k >= 3 && k <= len + 2));
                chk($sformatf("t%0d_last", k), out_last, int'(k == len + 2));
                chk($sformatf("t%0d_re", k), read_enable, int'(k <= len));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = ($urandom_range(0, 3) == 0);
                3: out_ready = ((rcnt % 14) >= 10);
                default: out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
            endcase
        end
    end

    int           issued = 0;
    int           accepted = 0;
    bit           stall_prev = 0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always @(negedge clk) begin
        beat_t        b;
        logic [A-1:0] ea;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            issued = 0;
            accepted = 0;
            stall_prev = 0;
        end else begin
            if (read_enable) begin
                issued++;
                if (addr_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    ea = addr_q.pop_front();
                    chk("address", address_read, ea);
                end
            end
            if (out_valid && out_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", out_data, b.data);
                    chk("beat_last", out_last, b.last);
                end
            end
            if (read_enable) chk("outstanding_gt2", int'((issued - accepted) > 2), 0);
            if (!out_valid) chk("last_without_valid", out_last, 0);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) seen_dones++;
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_address = '0;
        burst_length = '0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", read_enable, 0);
        chk("rst_addr", address_read, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        ready_mode = 0;
        timing_burst(5, 4);
        timing_burst(1022, 4);
        timing_burst(0, 0);

        ready_mode = 4;
        queue_burst(200, 8);
        start_burst(200, 8);
        wait_done(200);
        ready_mode = 3;
        queue_burst(400, 8);
        start_burst(400, 8);
        wait_done(300);
        ready_mode = 2;
        queue_burst(1020, 8);
        start_burst(1020, 8);
        wait_done(300);

        ready_mode = 1;
        queue_burst(600, 16);
        start_burst(600, 16);
        repeat (4) @(posedge clk);
        #1;
        start_burst(100, 5);
        wait_done(300);

        ready_mode = 0;
        queue_burst(0, 1024);
        start_burst(0, 1024);
        wait_done(1200);

        queue_burst(300, 16);
        start_burst(300, 16);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_dones--;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_re", read_enable, 0);
        chk("mid_rst_addr", address_read, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);
        @(posedge clk);
        #1;
        timing_burst(10, 2);

        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
        for (int n = 0; n < 30; n++) begin
            int a;
            int l;
            a = $urandom_range(0, DEPTH - 1);
            l = (n % 7 == 3) ? 0 : $urandom_range(1, 40);
            ready_mode = $urandom_range(0, 4);
            queue_burst(a, l);
            start_burst(a, l);
            wait_done(20 * l + 50);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("beats_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("done_count", seen_dones, exp_dones);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
